seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 214 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- sequential ALU with registered result and flags.
//
// Seven single-cycle operations complete at the edge that samples start.
// Opcode 111 (MUL) is an unsigned shift-add multiply that takes WIDTH cycles.
// The multiplier exists only when SEQ_ALU_MUL_EN is defined. Without it,
// opcode 111 completes in one cycle with Cbus=0, z=1, c=1.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous, active-high reset
//   start        operation request, sampled only while idle
//   alu_control  opcode: 000 PASA, 001 ADD, 010 SUB, 011 PAS,
//                        100 MUL2, 101 DIV2, 110 DECAC, 111 MUL
//   Abus, Bbus   operands (WIDTH bits)
//   Cbus         registered result
//   z            registered zero flag (new Cbus == 0)
//   c            registered carry / borrow / overflow flag
//   busy         high while a multiply is in progress
//   done         one-cycle pulse after Cbus/z/c take a new value
//
// Configuration macro: SEQ_ALU_MUL_EN
// -----------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] Abus,
  input  logic [WIDTH-1:0] Bbus,
  output logic [WIDTH-1:0] Cbus,
  output logic             z,
  output logic             c,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_PASA  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_PAS   = 3'b011;
  localparam logic [2:0] OP_MUL2  = 3'b100;
  localparam logic [2:0] OP_DIV2  = 3'b101;
  localparam logic [2:0] OP_DECAC = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  logic [WIDTH-1:0] cbus_reg, cbus_next;
  logic             z_reg, z_next;
  logic             c_reg, c_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  // Single-cycle result, computed straight from the inputs so it can be
  // loaded at the same edge that samples start.
  logic [WIDTH-1:0] alu_res;
  logic             alu_cy;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH:0]   dec_diff;

  assign add_sum  = {1'b0, Abus} + {1'b0, Bbus};
  // The extra top bit of each difference is the borrow out.
  assign sub_diff = {1'b0, Abus} - {1'b0, Bbus};
  assign dec_diff = {1'b0, Abus} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    case (alu_control)
      OP_PASA:  alu_res = Abus;
      OP_ADD:   {alu_cy, alu_res} = add_sum;
      OP_SUB:   {alu_cy, alu_res} = sub_diff;
      OP_PAS:   alu_res = Bbus;
      OP_MUL2:  begin
        alu_res = {Bbus[WIDTH-2:0], 1'b0};
        alu_cy  = Bbus[WIDTH-1];
      end
      OP_DIV2:  begin
        alu_res = {1'b0, Bbus[WIDTH-1:1]};
        alu_cy  = Bbus[0];
      end
      OP_DECAC: {alu_cy, alu_res} = dec_diff;
      default: begin
`ifdef SEQ_ALU_MUL_EN
        // MUL is handled by the multi-cycle path; this value is never loaded.
        alu_res = '0;
        alu_cy  = 1'b0;
`else
        // No multiplier: MUL reports a zero result with the overflow flag set.
        alu_res = '0;
        alu_cy  = 1'b1;
`endif
      end
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   mcand_reg, mcand_next;   // latched A, shifted left each iteration
  logic [WIDTH-1:0]     mplier_reg, mplier_next; // latched B, shifted right each iteration
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [CW-1:0]        count_reg, count_next;
  logic [2*WIDTH-1:0]   partial;

  // Accumulator value after the current multiplier bit has been applied.
  assign partial = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
`endif

  always_comb begin
    cbus_next = cbus_reg;
    z_next    = z_reg;
    c_next    = c_reg;
    busy_next = busy_reg;
    done_next = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    count_next  = count_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (alu_control == OP_MUL) begin
            state_next  = MUL;
            busy_next   = 1'b1;
            mcand_next  = {{WIDTH{1'b0}}, Abus};
            mplier_next = Bbus;
            acc_next    = '0;
            count_next  = '0;
          end else begin
            cbus_next = alu_res;
            c_next    = alu_cy;
            z_next    = (alu_res == '0);
            done_next = 1'b1;
          end
        end
      end
      MUL: begin
        acc_next    = partial;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        count_next  = count_reg + CW'(1);
        if (count_reg == LAST_ITER) begin
          // Last multiplier bit: publish the product straight from partial.
          state_next = IDLE;
          busy_next  = 1'b0;
          count_next = '0;
          cbus_next  = partial[WIDTH-1:0];
          c_next     = |partial[2*WIDTH-1:WIDTH];
          z_next     = (partial[WIDTH-1:0] == '0);
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
`else
    if (start) begin
      cbus_next = alu_res;
      c_next    = alu_cy;
      z_next    = (alu_res == '0);
      done_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cbus_reg   <= '0;
      z_reg      <= 1'b0;
      c_reg      <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
`endif
    end else begin
      cbus_reg   <= cbus_next;
      z_reg      <= z_next;
      c_reg      <= c_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
`ifdef SEQ_ALU_MUL_EN
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      count_reg  <= count_next;
`endif
    end
  end

  assign Cbus = cbus_reg;
  assign z    = z_reg;
  assign c    = c_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu -- randomized self-checking bench for seq_alu.
// Expected results come from an arithmetic reference model of each opcode.
// Honors SEQ_ALU_MUL_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_seq_alu;

  localparam int W = 17;
  localparam longint unsigned MASK = (64'd1 << W) - 1;
`ifdef SEQ_ALU_MUL_EN
  localparam bit MUL_BUILD = 1'b1;
`else
  localparam bit MUL_BUILD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   alu_control;
  logic [W-1:0] Abus, Bbus, Cbus;
  logic         z, c, busy, done;

  int n_pass  = 0;
  int n_total = 0;

  longint unsigned exp_cbus = 0;
  bit              exp_z    = 1'b0;
  bit              exp_c    = 1'b0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .alu_control (alu_control),
    .Abus        (Abus),
    .Bbus        (Bbus),
    .Cbus        (Cbus),
    .z           (z),
    .c           (c),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Reference behaviour of each opcode, in plain integer arithmetic.
  function automatic void model(input int op, input longint unsigned a, input longint unsigned b,
                                output longint unsigned r, output bit cy);
    longint unsigned p;
    case (op)
      0: begin r = a; cy = 0; end
      1: begin p = a + b; r = p & MASK; cy = (p > MASK); end
      2: begin r = (a - b) & MASK; cy = (a < b); end
      3: begin r = b; cy = 0; end
      4: begin r = (b * 2) & MASK; cy = (b >= (64'd1 << (W - 1))); end
      5: begin r = b / 2; cy = (b % 2) == 1; end
      6: begin r = (a - 1) & MASK; cy = (a == 0); end
      default: begin
        if (MUL_BUILD) begin
          p = a * b; r = p & MASK; cy = (p > MASK);
        end else begin
          r = 0; cy = 1;
        end
      end
    endcase
  endfunction

  function automatic longint unsigned pick();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return MASK;
      2: return 1;
      3: return 64'd1 << (W - 1);
      default: return longint'($urandom) & MASK;
    endcase
  endfunction

  // Issue one operation (called away from the clock edge) and check its result.
  // intrude: raise start with an ADD at MUL cycle 5; it must be ignored.
  task automatic do_op(input int op, input longint unsigned a, input longint unsigned b,
                       input bit intrude);
    longint unsigned r;
    bit cy;
    int k;
    alu_control = 3'(op);
    Abus  = W'(a);
    Bbus  = W'(b);
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    // Operands change after sampling; the running op must not see them.
    Abus = W'($urandom);
    Bbus = W'($urandom);
    model(op, a, b, r, cy);
    if (MUL_BUILD && op == 7) begin
      check("mul_busy_rise", busy, 1);
      check("mul_done_early", done, 0);
      k = 0;
      while (!done && k < W + 4) begin
        if (intrude && k == 4) begin
          alu_control = 3'b001;
          start = 1'b1;
        end
        @(posedge clk) #1;
        start = 1'b0;
        k++;
        if (!done) check("mul_busy_mid", busy, 1);
      end
      check("mul_latency", k, W);
    end
    check("done_pulse", done, 1);
    check("busy_low", busy, 0);
    check("cbus", Cbus, r);
    check("z", z, (r == 0));
    check("c", c, cy);
    exp_cbus = r;
    exp_z    = (r == 0);
    exp_c    = cy;
    $display("op=%0d A=0x%05h B=0x%05h -> Cbus=0x%05h z=%0b c=%0b (model 0x%05h %0b %0b)",
             op, a, b, Cbus, z, c, r, (r == 0), cy);
  endtask

  // One idle cycle: done must drop and the result must hold.
  task automatic idle();
    @(posedge clk) #1;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("hold_cbus", Cbus, exp_cbus);
    check("hold_z", z, exp_z);
    check("hold_c", c, exp_c);
  endtask

  // Asynchronous reset pulse between clock edges (called at edge+1).
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_cbus", Cbus, 0);
    check("rst_z", z, 0);
    check("rst_c", c, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #2 rst = 1'b0;
    exp_cbus = 0;
    exp_z    = 1'b0;
    exp_c    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    alu_control = 3'b000;
    Abus = '0;
    Bbus = '0;
    #1;
    // No clock edge yet: only the asynchronous reset can have cleared these.
    check("reset_cbus", Cbus, 0);
    check("reset_z", z, 0);
    check("reset_c", c, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    #12 rst = 1'b0;
    @(posedge clk) #1;

    // Directed vectors.
    do_op(1, 64'h1FFFF, 64'h00001, 0);
    check("add_wrap_cbus", Cbus, 0);
    check("add_wrap_z", z, 1);
    check("add_wrap_c", c, 1);
    idle();
    do_op(2, 5, 7, 0);
    check("sub_borrow_cbus", Cbus, 64'h1FFFE);
    check("sub_borrow_c", c, 1);
    do_op(6, 0, 0, 0);
    check("decac_zero_cbus", Cbus, 64'h1FFFF);
    check("decac_zero_c", c, 1);
    idle();

    if (MUL_BUILD) begin
      do_op(7, 300, 400, 0);
      check("mul_300_400", Cbus, 64'h1D4C0);
      do_op(7, 1000, 1000, 0);
      check("mul_1000_1000", Cbus, 64'h14240);
      check("mul_1000_ovf", c, 1);
      idle();
      do_op(7, 123, 45, 1);
      idle();
      idle();
      // Reset in the middle of a multiply: aborted, no done pulse.
      alu_control = 3'b111;
      Abus = W'(321);
      Bbus = W'(654);
      start = 1'b1;
      @(posedge clk) #1;
      start = 1'b0;
      repeat (7) @(posedge clk) #1;
      pulse_reset();
      repeat (W + 2) idle();
    end else begin
      do_op(7, 300, 400, 0);
      check("mul_off_cbus", Cbus, 0);
      check("mul_off_z", z, 1);
      check("mul_off_c", c, 1);
      idle();
      do_op(3, 64'h00123, 64'h04567, 0);
      @(posedge clk) #1;
      pulse_reset();
      repeat (3) idle();
    end
    do_op(3, 0, 64'h00ABC, 0);
    check("pas_after_rst", Cbus, 64'h00ABC);
    idle();

    // Randomized sequence; back-to-back ops when no idle cycle is inserted.
    for (int i = 0; i < 60; i++) begin
      do_op(int'($urandom_range(0, 7)), pick(), pick(), 0);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
